// File: rtl/piano_pkg.sv
// Shared definitions for the piano song path: event word layout, END marker, sequencer states.
package piano_pkg;

    localparam int unsigned EVENT_W   = 8;
    localparam int unsigned NOTE_W    = 4;
    localparam int unsigned BEATS_W   = 3;
    localparam int unsigned REST_W    = 1;

    localparam int unsigned NOTE_LSB  = 0;
    localparam int unsigned BEATS_LSB = 4;
    localparam int unsigned REST_LSB  = 7;

    localparam logic [EVENT_W-1:0] END_EVENT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PLAY,
        GAP
    } state_t;

endpackage

// File: rtl/song_rom.sv
// Song event table with a registered (1-cycle latency) read.
// TABLE_SEL=0 selects the built-in tune, TABLE_SEL=1 a short characterisation table.
module song_rom
    import piano_pkg::*;
#(
    parameter int unsigned SONG_LEN  = 32,
    parameter int unsigned TABLE_SEL = 0,
    localparam int unsigned AW = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
    input  logic               clk,
    input  logic [AW-1:0]      addr,
    output logic [EVENT_W-1:0] data
);

    logic [31:0] idx;

    assign idx = 32'(addr);

    // Registered table lookup; unlisted addresses read as END.
    always_ff @(posedge clk) begin
        data <= END_EVENT;
        if (TABLE_SEL == 1) begin
            case (idx)
                0:       data <= 8'h13;   // note 3, 2 beats
                1:       data <= 8'h85;   // rest, 1 beat
                default: data <= END_EVENT;
            endcase
        end else begin
            case (idx)
                0:       data <= 8'h04;
                1:       data <= 8'h04;
                2:       data <= 8'h05;
                3:       data <= 8'h07;
                4:       data <= 8'h07;
                5:       data <= 8'h05;
                6:       data <= 8'h04;
                7:       data <= 8'h02;
                8:       data <= 8'h00;
                9:       data <= 8'h00;
                10:      data <= 8'h02;
                11:      data <= 8'h04;
                12:      data <= 8'h14;
                13:      data <= 8'h12;
                14:      data <= 8'h80;
                default: data <= END_EVENT;
            endcase
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Autoplay sequencer feeding the tone generator's note/hush inputs.
// Each event = PLAY + articulation GAP + FETCH, totalling beats*BEAT_CYCLES cycles.
// Optional macro SONG_LOOP_EN: wrap to event 0 on END instead of returning to IDLE.
module song_sequencer
    import piano_pkg::*;
#(
    parameter int unsigned BEAT_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 1_000_000,
    parameter int unsigned SONG_LEN    = 32,
    parameter int unsigned TABLE_SEL   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic [NOTE_W-1:0] note,
    output logic              hush,
    output logic              busy,
    output logic              done
);

    localparam int unsigned AW = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
    localparam int unsigned PW = AW + 1;   // one extra bit so addr can reach SONG_LEN
    localparam int unsigned CW = $clog2(8 * BEAT_CYCLES);

    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 2);
    localparam logic [CW-1:0] LOAD_1   = CW'(1 * BEAT_CYCLES - GAP_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_2   = CW'(2 * BEAT_CYCLES - GAP_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_3   = CW'(3 * BEAT_CYCLES - GAP_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_4   = CW'(4 * BEAT_CYCLES - GAP_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_5   = CW'(5 * BEAT_CYCLES - GAP_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_6   = CW'(6 * BEAT_CYCLES - GAP_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_7   = CW'(7 * BEAT_CYCLES - GAP_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_8   = CW'(8 * BEAT_CYCLES - GAP_CYCLES - 1);

    state_t              state, state_nxt;
    logic [PW-1:0]       addr, addr_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [NOTE_W-1:0]   note_nxt;
    logic                hush_nxt, busy_nxt, done_nxt;

    logic [EVENT_W-1:0]  ev;
    logic [NOTE_W-1:0]   ev_note;
    logic [BEATS_W-1:0]  ev_beats_m1;
    logic [REST_W-1:0]   ev_rest;
    logic                ev_end;
    logic [CW-1:0]       play_load;

    // ROM is addressed with the next address so the event is ready during FETCH.
    song_rom #(
        .SONG_LEN  (SONG_LEN),
        .TABLE_SEL (TABLE_SEL)
    ) u_rom (
        .clk  (clk),
        .addr (addr_nxt[AW-1:0]),
        .data (ev)
    );

    assign ev_note     = ev[NOTE_LSB  +: NOTE_W];
    assign ev_beats_m1 = ev[BEATS_LSB +: BEATS_W];
    assign ev_rest     = ev[REST_LSB  +: REST_W];
    assign ev_end      = (ev == END_EVENT) || (addr == PW'(SONG_LEN));

    // Select the elaborated PLAY counter preload for the event length.
    always_comb begin
        play_load = LOAD_1;
        case (ev_beats_m1)
            3'd0:    play_load = LOAD_1;
            3'd1:    play_load = LOAD_2;
            3'd2:    play_load = LOAD_3;
            3'd3:    play_load = LOAD_4;
            3'd4:    play_load = LOAD_5;
            3'd5:    play_load = LOAD_6;
            3'd6:    play_load = LOAD_7;
            default: play_load = LOAD_8;
        endcase
    end

    // State, address, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            addr  <= '0;
            cnt   <= '0;
            note  <= '0;
            hush  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            cnt   <= cnt_nxt;
            note  <= note_nxt;
            hush  <= hush_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state and next-output decode; outputs are computed for the state being entered.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        cnt_nxt   = cnt;
        note_nxt  = note;
        hush_nxt  = hush;
        busy_nxt  = busy;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                note_nxt = '0;
                hush_nxt = 1'b1;
                busy_nxt = 1'b0;
                if (start) begin
                    state_nxt = FETCH;
                    addr_nxt  = '0;
                    busy_nxt  = 1'b1;
                end
            end
            FETCH: begin
                if (ev_end) begin
                    done_nxt = 1'b1;
`ifdef SONG_LOOP_EN
                    state_nxt = FETCH;
                    addr_nxt  = '0;
`else
                    state_nxt = IDLE;
                    addr_nxt  = '0;
                    note_nxt  = '0;
                    hush_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
`endif
                end else begin
                    state_nxt = PLAY;
                    cnt_nxt   = play_load;
                    note_nxt  = ev_note;
                    hush_nxt  = ev_rest[0];
                end
            end
            PLAY: begin
                if (cnt == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LOAD;
                    hush_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = FETCH;
                    addr_nxt  = addr + 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort from any state; also makes stop win over a simultaneous start.
        if (stop) begin
            state_nxt = IDLE;
            addr_nxt  = '0;
            cnt_nxt   = '0;
            note_nxt  = '0;
            hush_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b0;
        end
    end

endmodule
